// File: rtl/frame_serializer.sv
// Frame serializer: COMMA header + NUM_WORDS symbols per frame, shifted out 1 bit/clk MSB first, COMMA idle fill.
// Latency: acceptance to sof_o is 2..SYM_BITS+1 clk when idle; a one-deep buffer allows gapless back-to-back frames.
// Backpressure: ready_o = ~full_q; optional per-symbol even parity bit under `ifdef SER_PARITY_EN.
module frame_serializer #(
    parameter int unsigned          NUM_WORDS = 3,
    parameter int unsigned          DATA_W    = 8,
    parameter logic [DATA_W-1:0]    COMMA     = 8'h3C
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               valid_i,
    output logic                               ready_o,
    input  logic [NUM_WORDS*(DATA_W+1)-1:0]    data_i,
    output logic                               data_o,
    output logic                               sym_o,
    output logic                               sof_o
);
    localparam int unsigned SYM_W = DATA_W + 1;
`ifdef SER_PARITY_EN
    localparam int unsigned SYM_BITS = SYM_W + 1;
`else
    localparam int unsigned SYM_BITS = SYM_W;
`endif
    localparam int unsigned FRAME_W = NUM_WORDS * SYM_W;
    localparam int unsigned CNT_W   = $clog2(SYM_BITS);
    localparam int unsigned IDX_W   = $clog2(NUM_WORDS + 1);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SYM_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [SYM_W-1:0] COMMA_W  = {1'b1, COMMA};

    // Serialised form of a symbol: parity (even, over all SYM_W bits) goes last.
    function automatic logic [SYM_BITS-1:0] make_sym(input logic [SYM_W-1:0] s);
`ifdef SER_PARITY_EN
        return {s, ^s};
`else
        return s;
`endif
    endfunction

    localparam logic [SYM_BITS-1:0] COMMA_SYM = make_sym(COMMA_W);

    typedef enum logic {ST_IDLE, ST_FRAME} state_t;

    state_t                 state;
    logic [SYM_BITS-1:0]    shift_q;
    logic [CNT_W-1:0]       bit_cnt;
    logic [IDX_W-1:0]       word_idx;
    logic                   full_q;
    logic                   sof_q;
    logic [FRAME_W-1:0]     buf_q;
    logic [FRAME_W-1:0]     frame_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            shift_q  <= COMMA_SYM;
            bit_cnt  <= '0;
            word_idx <= '0;
            full_q   <= 1'b0;
            sof_q    <= 1'b0;
            buf_q    <= '0;
            frame_q  <= '0;
        end else begin
            sof_q <= 1'b0;
            // Acceptance and header load are mutually exclusive: one needs full_q low, the other high.
            if (valid_i && !full_q) begin
                buf_q  <= data_i;
                full_q <= 1'b1;
            end
            if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
                case (state)
                    ST_IDLE: begin
                        shift_q <= COMMA_SYM;
                        if (full_q) begin
                            sof_q    <= 1'b1;
                            word_idx <= '0;
                            frame_q  <= buf_q;
                            full_q   <= 1'b0;
                            state    <= ST_FRAME;
                        end
                    end
                    ST_FRAME: begin
                        shift_q  <= make_sym(frame_q[int'(word_idx)*SYM_W +: SYM_W]);
                        word_idx <= word_idx + 1'b1;
                        if (word_idx == LAST_IDX) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        shift_q <= COMMA_SYM;
                        state   <= ST_IDLE;
                    end
                endcase
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
                shift_q <= {shift_q[SYM_BITS-2:0], 1'b0};
            end
        end
    end

    assign ready_o = ~full_q;
    assign data_o  = shift_q[SYM_BITS-1];
    assign sym_o   = (bit_cnt == '0);
    assign sof_o   = sof_q;

endmodule

// File: tb/tb_frame_serializer.sv
// Directed bench for frame_serializer (NUM_WORDS=3, DATA_W=8, COMMA=8'h3C); symbol-level vector table plus corner sequences.
module tb_frame_serializer;
`ifdef SER_PARITY_EN
    localparam int SB = 10;
`else
    localparam int SB = 9;
`endif

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [26:0] data_i = '0;
    logic        data_o;
    logic        sym_o;
    logic        sof_o;

    int checks = 0;
    int errors = 0;
    int t = 0;

    frame_serializer #(.NUM_WORDS(3), .DATA_W(8), .COMMA(8'h3C)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .data_o  (data_o),
        .sym_o   (sym_o),
        .sof_o   (sof_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [26:0] dat;
        logic        exp_rdy;
        logic [8:0]  exp_sym;
        logic        exp_sof;
    } vec_t;

    localparam logic [26:0] F1 = {9'h1BC, 9'h0A5, 9'h055};
    localparam logic [26:0] F2 = {9'h0F0, 9'h10F, 9'h001};
    localparam logic [26:0] F3 = {9'h1FF, 9'h1FF, 9'h1FF};
    localparam logic [26:0] F4 = {9'h033, 9'h1C3, 9'h0AA};

    function automatic logic [SB-1:0] ser(input logic [8:0] s);
`ifdef SER_PARITY_EN
        return {s, ^s};
`else
        return s;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0d: got %0h expected %0h", name, t, act, exp);
        end
    endtask

    // Checks one full symbol, starting at its first bit, and leaves the bench on the next symbol's first bit.
    task automatic check_sym(input logic [8:0] s, input logic sof, input string name);
        logic [SB-1:0] bits;
        bits = ser(s);
        for (int b = 0; b < SB; b++) begin
            check(name, {13'd0, data_o, sym_o, sof_o},
                  {13'd0, bits[SB-1-b], (b == 0), (sof && b == 0)});
            tick();
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        t = 0;
    endtask

    initial begin
        vec_t vecs[16];
        int   n;
        logic [SB-1:0] w1bits;

        vecs[0]  = '{1'b1, F1, 1'b1, 9'h13C, 1'b0};
        vecs[1]  = '{1'b0, '0, 1'b1, 9'h13C, 1'b1};
        vecs[2]  = '{1'b0, '0, 1'b1, 9'h055, 1'b0};
        vecs[3]  = '{1'b0, '0, 1'b1, 9'h0A5, 1'b0};
        vecs[4]  = '{1'b0, '0, 1'b1, 9'h1BC, 1'b0};
        vecs[5]  = '{1'b0, '0, 1'b1, 9'h13C, 1'b0};
        vecs[6]  = '{1'b1, F2, 1'b1, 9'h13C, 1'b0};
        vecs[7]  = '{1'b1, F4, 1'b1, 9'h13C, 1'b1};
        vecs[8]  = '{1'b1, F3, 1'b0, 9'h001, 1'b0};
        vecs[9]  = '{1'b1, F3, 1'b0, 9'h10F, 1'b0};
        vecs[10] = '{1'b1, F3, 1'b0, 9'h0F0, 1'b0};
        vecs[11] = '{1'b0, '0, 1'b1, 9'h13C, 1'b1};
        vecs[12] = '{1'b0, '0, 1'b1, 9'h0AA, 1'b0};
        vecs[13] = '{1'b0, '0, 1'b1, 9'h1C3, 1'b0};
        vecs[14] = '{1'b0, '0, 1'b1, 9'h033, 1'b0};
        vecs[15] = '{1'b0, '0, 1'b1, 9'h13C, 1'b0};

        // Reset state and idle comma stream
        do_reset();
        check("reset_ready", {15'd0, ready_o}, 16'd1);
        check("reset_line", {13'd0, data_o, sym_o, sof_o}, 16'b110);
        for (int k = 0; k < 3; k++) begin
            check("idle_ready", {15'd0, ready_o}, 16'd1);
            check_sym(9'h13C, 1'b0, "idle_comma");
        end

        // Single frame, then back-to-back frames with valid held
        for (int i = 0; i < 16; i++) begin
            check("vec_ready", {15'd0, ready_o}, {15'd0, vecs[i].exp_rdy});
            valid_i = vecs[i].vld;
            data_i  = vecs[i].dat;
            check_sym(vecs[i].exp_sym, vecs[i].exp_sof, "vec_sym");
        end
        valid_i = 1'b0;
        data_i  = '0;

        // Valid asserted in the boundary cycle: header is one full symbol later
        while (t % SB != SB - 1) tick();
        check("bnd_ready", {15'd0, ready_o}, 16'd1);
        valid_i = 1'b1;
        data_i  = F1;
        tick();
        valid_i = 1'b0;
        data_i  = '0;
        n = 1;
        while (sof_o !== 1'b1 && n < 4 * SB) begin
            tick();
            n++;
        end
        check("bnd_latency", 16'(n), 16'(SB + 1));
        check_sym(9'h13C, 1'b1, "bnd_hdr");
        check_sym(9'h055, 1'b0, "bnd_w0");
        check_sym(9'h0A5, 1'b0, "bnd_w1");
        check_sym(9'h1BC, 1'b0, "bnd_w2");
        check_sym(9'h13C, 1'b0, "bnd_idle");

        // Reset mid-word with a second frame buffered: both are dropped
        valid_i = 1'b1;
        data_i  = F1;
        check_sym(9'h13C, 1'b0, "rst_pre");
        valid_i = 1'b1;
        data_i  = F3;
        check_sym(9'h13C, 1'b1, "rst_hdr");
        valid_i = 1'b0;
        data_i  = '0;
        check("rst_buffered", {15'd0, ready_o}, 16'd0);
        check_sym(9'h055, 1'b0, "rst_w0");
        w1bits = ser(9'h0A5);
        for (int b = 0; b < 4; b++) begin
            check("rst_w1", {15'd0, data_o}, {15'd0, w1bits[SB-1-b]});
            tick();
        end
        do_reset();
        check("rst_after", {12'd0, data_o, sym_o, sof_o, ready_o}, 16'b1101);
        for (int k = 0; k < 6; k++) begin
            check("rst_idle_ready", {15'd0, ready_o}, 16'd1);
            check_sym(9'h13C, 1'b0, "rst_idle");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end
endmodule
